// File: rtl/riscv_types.sv
// Shared types for the memory-access stage: control vector, FSM states, funct3 encodings.
package riscv_types;

  // Control vector carried down the pipeline
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [2:0] funct3;
  } riscv_control_t;

  // Memory-access FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size, taken from funct3[1:0] for loads and stores alike
  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
module load_extend
  import riscv_types::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rdata_i,
  input  logic [1:0]       off_i,
  input  logic [2:0]       funct3_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] shifted;

  // Shift the addressed lane down to bit 0, then extend by load type
  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    data_o  = shifted;
    case (funct3_i)
      F3_LB:   data_o = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      F3_LH:   data_o = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      F3_LBU:  data_o = {{(WIDTH-8){1'b0}}, shifted[7:0]};
      F3_LHU:  data_o = {{(WIDTH-16){1'b0}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory-access stage: issues one data-bus transaction per load/store,
// stalls upstream while it is outstanding, and registers results for writeback.
module mem_access_stage
  import riscv_types::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned INDEX = 5
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 valid_in,
  input  logic [WIDTH-1:0]     alu_res_in,
  input  logic [WIDTH-1:0]     drs2_in,
  input  logic [INDEX-1:0]     rd_in,
  input  logic                 zero_in,
  input  logic [WIDTH-1:0]     pc_branch_in,
  input  riscv_control_t       ctrl_vector_in,
  output logic                 dmem_req_out,
  output logic                 dmem_we_out,
  output logic [WIDTH-1:0]     dmem_addr_out,
  output logic [WIDTH-1:0]     dmem_wdata_out,
  output logic [3:0]           dmem_be_out,
  input  logic                 dmem_ack_in,
  input  logic [WIDTH-1:0]     dmem_rdata_in,
  output logic                 stall_out,
  output logic                 pc_src_out,
  output logic [WIDTH-1:0]     pc_branch_out,
  output logic                 valid_out,
  output logic                 misalign_out,
  output logic [WIDTH-1:0]     load_data_out,
  output logic [WIDTH-1:0]     alu_res_out,
  output logic [INDEX-1:0]     rd_out,
  output riscv_control_t       ctrl_vector_out
);

  mem_state_e       state_q;
  logic             req_q, we_q, valid_q, misalign_q;
  logic [WIDTH-1:0] addr_q, wdata_q, load_data_q, alu_res_q;
  logic [3:0]       be_q;
  logic [1:0]       off_q;
  logic [INDEX-1:0] rd_q;
  riscv_control_t   ctrl_q;

  logic             is_mem_d, misalign_d, accept_d;
  logic [WIDTH-1:0] addr_d, wdata_d, ext_d;
  logic [3:0]       be_d;
  riscv_control_t   ctrl_clr_d;

  // Decode the incoming slot: alignment, bus address, byte enables, replicated store data
  always_comb begin
    is_mem_d   = ctrl_vector_in.mem_read | ctrl_vector_in.mem_write;
    addr_d     = {alu_res_in[WIDTH-1:2], 2'b00};
    misalign_d = 1'b0;
    be_d       = 4'b1111;
    wdata_d    = drs2_in;
    ctrl_clr_d = ctrl_vector_in;
    ctrl_clr_d.reg_write = 1'b0;
    case (ctrl_vector_in.funct3[1:0])
      SZ_H:    misalign_d = alu_res_in[0];
      SZ_W:    misalign_d = |alu_res_in[1:0];
      default: misalign_d = 1'b0;
    endcase
    if (ctrl_vector_in.mem_write) begin
      case (ctrl_vector_in.funct3)
        F3_SB: begin
          be_d    = 4'b0001 << alu_res_in[1:0];
          wdata_d = {(WIDTH/8){drs2_in[7:0]}};
        end
        F3_SH: begin
          be_d    = 4'b0011 << alu_res_in[1:0];
          wdata_d = {(WIDTH/16){drs2_in[15:0]}};
        end
        default: be_d = 4'b1111;
      endcase
    end
    accept_d = (state_q == ST_IDLE) & valid_in & is_mem_d & ~misalign_d;
  end

  load_extend #(.WIDTH(WIDTH)) u_load_extend (
    .rdata_i  (dmem_rdata_in),
    .off_i    (off_q),
    .funct3_i (ctrl_q.funct3),
    .data_o   (ext_d)
  );

  // Transaction FSM with registered bus and result outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      off_q       <= '0;
      valid_q     <= 1'b0;
      misalign_q  <= 1'b0;
      load_data_q <= '0;
      alu_res_q   <= '0;
      rd_q        <= '0;
      ctrl_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          valid_q    <= 1'b0;
          misalign_q <= 1'b0;
          if (valid_in) begin
            alu_res_q <= alu_res_in;
            if (is_mem_d && misalign_d) begin
              valid_q     <= 1'b1;
              misalign_q  <= 1'b1;
              rd_q        <= '0;
              ctrl_q      <= ctrl_clr_d;
              load_data_q <= '0;
            end else if (is_mem_d) begin
              req_q   <= 1'b1;
              we_q    <= ctrl_vector_in.mem_write;
              addr_q  <= addr_d;
              be_q    <= be_d;
              wdata_q <= wdata_d;
              off_q   <= alu_res_in[1:0];
              rd_q    <= rd_in;
              ctrl_q  <= ctrl_vector_in;
              state_q <= ST_REQ;
            end else begin
              valid_q     <= 1'b1;
              rd_q        <= rd_in;
              ctrl_q      <= ctrl_vector_in;
              load_data_q <= '0;
            end
          end
        end
        ST_REQ: begin
          if (dmem_ack_in) begin
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            valid_q     <= 1'b1;
            load_data_q <= ctrl_q.mem_read ? ext_d : '0;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Combinational stall and branch decision, forced low while reset is asserted
  assign stall_out     = rst_in & (accept_d | (state_q == ST_REQ));
  assign pc_src_out    = rst_in & valid_in & ctrl_vector_in.branch & zero_in & (state_q == ST_IDLE);
  assign pc_branch_out = rst_in ? pc_branch_in : '0;

  assign dmem_req_out    = req_q;
  assign dmem_we_out     = we_q;
  assign dmem_addr_out   = addr_q;
  assign dmem_wdata_out  = wdata_q;
  assign dmem_be_out     = be_q;
  assign valid_out       = valid_q;
  assign misalign_out    = misalign_q;
  assign load_data_out   = load_data_q;
  assign alu_res_out     = alu_res_q;
  assign rd_out          = rd_q;
  assign ctrl_vector_out = ctrl_q;

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Parameters
REQ-001 SHALL have parameter WIDTH, default 32, meaning the datapath and address width.
REQ-002 SHALL have parameter INDEX, default 5, meaning the register-index width.

Interface (name  direction  width  meaning)
REQ-003 SHALL have clk_in  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_in  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have valid_in  in  1  upstream slot holds a live instruction.
REQ-006 SHALL have alu_res_in  in  WIDTH  effective address or ALU result.
REQ-007 SHALL have drs2_in  in  WIDTH  store data.
REQ-008 SHALL have rd_in  in  INDEX  destination register.
REQ-009 SHALL have zero_in  in  1  ALU zero flag.
REQ-010 SHALL have pc_branch_in  in  WIDTH  branch target.
REQ-011 SHALL have ctrl_vector_in  in  riscv_control_t  control vector (fields used: mem_read, mem_write, branch, reg_write, funct3).
REQ-012 SHALL have dmem_req_out, dmem_we_out  out  1 each  bus request and write enable.
REQ-013 SHALL have dmem_addr_out, dmem_wdata_out  out  WIDTH each  word-aligned address and lane-replicated store data.
REQ-014 SHALL have dmem_be_out  out  4  byte enables.
REQ-015 SHALL have dmem_ack_in  in  1  one-cycle bus completion pulse.
REQ-016 SHALL have dmem_rdata_in  in  WIDTH  read word, valid with the ack.
REQ-017 SHALL have stall_out  out  1  hold the upstream stages.
REQ-018 SHALL have pc_src_out  out  1  take the branch.
REQ-019 SHALL have pc_branch_out  out  WIDTH  forwarded branch target.
REQ-020 SHALL have valid_out, misalign_out  out  1 each  result valid; misaligned-access fault.
REQ-021 SHALL have load_data_out, alu_res_out  out  WIDTH each  extended load value; forwarded ALU result.
REQ-022 SHALL have rd_out  out  INDEX  destination register.
REQ-023 SHALL have ctrl_vector_out  out  riscv_control_t  forwarded control vector.

Function
REQ-024 SHALL implement the FSM states IDLE, REQ and DONE.
REQ-025 SHALL, in IDLE with valid_in and mem_read|mem_write and an aligned address, latch addr/data/ctrl/rd and go to REQ; stall_out=1 combinationally in that cycle.
REQ-026 SHALL hold dmem_req_out=1 with stable addr/we/be/wdata throughout REQ; stall_out=1.
REQ-027 SHALL, on dmem_ack_in in REQ, capture and extend rdata and go to DONE; an ack outside REQ is ignored.
REQ-028 SHALL, in DONE, pulse valid_out for one cycle with stall_out=0, then return to IDLE; minimum memory-op latency is 3 cycles (ack on the first REQ cycle).
REQ-029 SHALL register non-memory ops with valid_in in IDLE straight through: valid_out one cycle later; FSM stays IDLE; no stall.
REQ-030 SHALL compute pc_src_out = valid_in & branch & zero_in & (state==IDLE), combinationally; pc_branch_out = pc_branch_in.
REQ-031 SHALL sign-extend loads per funct3: 000 LB, 001 LH, 010 LW, 100 LBU (zero-extend), 101 LHU (zero-extend); lane selected by addr[1:0].
REQ-032 SHALL, for stores, set funct3 000 be=0001<<a[1:0], 001 be=0011<<a[1:0], 010 be=1111; replicate the byte/half across wdata.
REQ-033 SHALL treat halfword at a[0]=1 and word at a[1:0]!=0 as misaligned: no bus request; registered valid_out=1, misalign_out=1, reg_write cleared in ctrl_vector_out, rd_out=0.
REQ-034 SHALL keep dmem_addr_out[1:0]=00.
REQ-035 SHALL ignore valid_in while not in IDLE; the upstream is stalled.

Reset
REQ-036 SHALL, on rst_in low, immediately force IDLE and zero every output (dmem_req_out dropped even mid-REQ).
REQ-037 SHALL drop a pending transaction aborted by reset; its late ack is ignored.

Structure
REQ-038 SHALL place the FSM state enum and the funct3 load/store encodings in riscv_types, alongside riscv_control_t.
REQ-039 SHALL put load lane selection and extension in the combinational sub-module load_extend.

Verification
REQ-040 SHALL cover: LW at 0x100, ack after 2 waits, rdata 0xDEADBEEF -> load_data_out 0xDEADBEEF; stall high 3 cycles.
REQ-041 SHALL cover: LB at 0x103, rdata 0x80000000 -> 0xFFFFFF80; LBU -> 0x00000080.
REQ-042 SHALL cover: SH at 0x102 with drs2 0x1234ABCD -> be 1100, wdata 0xABCDABCD, addr 0x100, we=1.
REQ-043 SHALL cover: LW at 0x101 -> no dmem_req_out, misalign_out=1, rd_out=0, no stall.
REQ-044 SHALL cover: BEQ with zero_in=1 in IDLE -> pc_src_out=1 same cycle; with zero_in=0 -> 0.
REQ-045 SHALL cover: rst_in low mid-REQ -> req drops asynchronously; a late ack yields no valid_out.
